imem_fetch_responder: RTL and testbench

- Instruction-memory responder on the fetch side of the core. It accepts word fetch requests addressed by the program counter and returns the instruction word after a fixed pipeline latency.
- Uses a valid/ready handshake on both request and response, with output backpressure.
- Discards all in-flight and buffered fetches on a branch flush.
- Contents are loaded through a simple write port before or during execution.

---
 rtl/imem_fetch_responder.sv | 168 ++++++++++++++++
 tb/tb_imem_fetch_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - fixed-latency instruction fetch responder with flush and load port
// Optional IMEM_PERF_EN adds fetch and flush-drop performance counters.
module imem_fetch_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    input  logic                           flush,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_data,
    output logic [31:0]                    rsp_addr,
    output logic                           rsp_err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic                           busy
`ifdef IMEM_PERF_EN
    ,
    output logic [31:0]                    perf_fetch_cnt,
    output logic [31:0]                    perf_flush_drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int PW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAT_C    = CW'(LATENCY);
    localparam logic [PW-1:0] PTR_LAST = PW'(LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    logic          pipe_valid [LATENCY];
    logic [31:0]   pipe_addr  [LATENCY];
    logic          pipe_err   [LATENCY];
    logic [31:0]   pipe_data  [LATENCY];

    logic [31:0]   fifo_addr  [LATENCY];
    logic          fifo_err   [LATENCY];
    logic [31:0]   fifo_data  [LATENCY];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] credit;

    logic [31:0]   offset;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic [31:0]   rd_word;
    logic          fifo_empty;
    logic          last_valid;
    logic          accept;
    logic          rsp_hs;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Unsigned subtract makes addresses below BASE_ADDR wrap into the out-of-range region.
    assign offset  = req_addr - BASE_ADDR;
    assign req_err = (req_addr[1:0] != 2'b00) || ((offset >> 2) >= 32'(DEPTH_WORDS));
    assign req_idx = offset[AW+1:2];
    assign rd_word = mem[req_idx];

    assign fifo_empty = (fifo_cnt == '0);
    assign last_valid = pipe_valid[LATENCY-1];

    // With the FIFO empty the last pipeline stage is presented directly; if it is not
    // taken it moves into the FIFO, whose head then holds the same values stable.
    assign rsp_valid = fifo_empty ? last_valid : 1'b1;
    assign rsp_data  = !rsp_valid ? 32'h0 : (fifo_empty ? pipe_data[LATENCY-1] : fifo_data[rd_ptr]);
    assign rsp_addr  = !rsp_valid ? 32'h0 : (fifo_empty ? pipe_addr[LATENCY-1] : fifo_addr[rd_ptr]);
    assign rsp_err   = !rsp_valid ? 1'b0  : (fifo_empty ? pipe_err[LATENCY-1]  : fifo_err[rd_ptr]);

    assign rsp_hs    = rsp_valid && rsp_ready;
    assign pop       = rsp_hs && !fifo_empty;
    assign push      = last_valid && !(fifo_empty && rsp_ready);
    assign req_ready = !flush && ((credit < LAT_C) || rsp_hs);
    assign accept    = req_valid && req_ready;
    assign busy      = (credit != '0);

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_addr[i]  <= 32'h0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= 32'h0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_addr[0]  <= req_addr;
            pipe_err[0]   <= req_err;
            pipe_data[0]  <= req_err ? 32'h0 : rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_addr[wr_ptr] <= pipe_addr[LATENCY-1];
            fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
            fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            credit   <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            credit   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            credit   <= credit + CW'(accept) - CW'(rsp_hs);
        end
    end

`ifdef IMEM_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt      <= 32'h0;
            perf_flush_drop_cnt <= 32'h0;
        end else begin
            if (accept) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (flush) begin
                perf_flush_drop_cnt <= perf_flush_drop_cnt + 32'(credit) - 32'(rsp_hs);
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - directed self-checking bench for imem_fetch_responder
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        busy;
`ifdef IMEM_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY(2),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_addr(rsp_addr),
        .rsp_err(rsp_err),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy(busy)
`ifdef IMEM_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_drop_cnt(perf_flush_drop_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        flush     = 1'b0;
        load_en   = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_addr !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b data=%h addr=%h err=%b, want 0 0 0 0", rsp_valid, rsp_data, rsp_addr, rsp_err);
        end
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b req_ready=%b, want 0 1", busy, req_ready);
        end
`ifdef IMEM_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'h0 || perf_flush_drop_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_perf: fetch=%0d drop=%0d, want 0 0", perf_fetch_cnt, perf_flush_drop_cnt);
        end
`endif
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_addr = 10'(i);
            load_data = 32'hA0 + 32'(i);
            step();
        end
        load_en = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_data;
        for (int i = 0; i < 7; i++) begin
            req_valid = (i < 4);
            req_addr  = 32'(4 * i);
            @(negedge clk);
            if (i >= 2 && i < 6) begin
                exp_data = 32'hA0 + 32'(i - 2);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_addr !== 32'(4 * (i - 2)) || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_%0d: valid=%b data=%h addr=%h err=%b, want 1 %h %h 0",
                             i, rsp_valid, rsp_data, rsp_addr, rsp_err, exp_data, 4 * (i - 2));
                end
            end
            if (i == 6) begin
                checks++;
                if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_idle: valid=%b busy=%b, want 0 0", rsp_valid, busy);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = 32'(4 * acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            if (i >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== 32'hA0 || rsp_addr !== 32'h0) begin
                    errors++;
                    $display("FAIL bp_hold_%0d: valid=%b data=%h addr=%h, want 1 000000a0 0", i, rsp_valid, rsp_data, rsp_addr);
                end
            end
            step();
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (acc !== 2 || req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: accepted=%0d req_ready=%b busy=%b, want 2 0 1", acc, req_ready, busy);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hA0 || rsp_addr !== 32'h0) begin
            errors++;
            $display("FAIL bp_drain0: valid=%b data=%h addr=%h, want 1 000000a0 0", rsp_valid, rsp_data, rsp_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hA1 || rsp_addr !== 32'h4) begin
            errors++;
            $display("FAIL bp_drain1: valid=%b data=%h addr=%h, want 1 000000a1 4", rsp_valid, rsp_data, rsp_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b busy=%b, want 0 0", rsp_valid, busy);
        end
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] exp_addr [2];
        exp_addr[0] = 32'h0000_0002;
        exp_addr[1] = 32'h0000_1000;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 2);
            req_addr  = (i < 2) ? exp_addr[i] : 32'h0;
            @(negedge clk);
            if (i == 2 || i == 3) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_addr !== exp_addr[i-2]) begin
                    errors++;
                    $display("FAIL err_%0d: valid=%b err=%b data=%h addr=%h, want 1 1 0 %h",
                             i - 2, rsp_valid, rsp_err, rsp_data, rsp_addr, exp_addr[i-2]);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_addr  = 32'h4;
        step();
        flush     = 1'b1;
        req_addr  = 32'h8;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: req_ready=%b, want 0", req_ready);
        end
        step();
        flush     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: valid=%b busy=%b req_ready=%b, want 0 0 1", rsp_valid, busy, req_ready);
        end
`ifdef IMEM_PERF_EN
        checks++;
        if (perf_flush_drop_cnt !== 32'd2) begin
            errors++;
            $display("FAIL flush_perf: drop=%0d, want 2", perf_flush_drop_cnt);
        end
`endif
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_gap: valid=%b, want 0", rsp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hA2 || rsp_addr !== 32'h8) begin
            errors++;
            $display("FAIL flush_refetch: valid=%b data=%h addr=%h, want 1 000000a2 8", rsp_valid, rsp_data, rsp_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale: valid=%b busy=%b, want 0 0", rsp_valid, busy);
        end
        idle();
    endtask

    task automatic test_load_collision();
        load_en   = 1'b1;
        load_addr = 10'd1;
        load_data = 32'h0000_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        step();
        load_en   = 1'b0;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hA1) begin
            errors++;
            $display("FAIL load_old: valid=%b data=%h, want 1 000000a1", rsp_valid, rsp_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL load_new: valid=%b data=%h, want 1 0000beef", rsp_valid, rsp_data);
        end
        step();
        idle();
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_addr  = 32'h4;
        step();
        req_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: valid=%b busy=%b, want 1 1", rsp_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_now: valid=%b busy=%b req_ready=%b, want 0 0 1", rsp_valid, busy, req_ready);
        end
`ifdef IMEM_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'h0 || perf_flush_drop_cnt !== 32'h0) begin
            errors++;
            $display("FAIL arst_perf: fetch=%0d drop=%0d, want 0 0", perf_fetch_cnt, perf_flush_drop_cnt);
        end
`endif
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL arst_quiet_%0d: valid=%b, want 0", i, rsp_valid);
            end
            step();
        end
        req_valid = 1'b1;
        req_addr  = 32'hC;
        step();
        req_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hA3 || rsp_addr !== 32'hC) begin
            errors++;
            $display("FAIL arst_new: valid=%b data=%h addr=%h, want 1 000000a3 c", rsp_valid, rsp_data, rsp_addr);
        end
`ifdef IMEM_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd1) begin
            errors++;
            $display("FAIL arst_perf_cnt: fetch=%0d, want 1", perf_fetch_cnt);
        end
`endif
        step();
        idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        load_addr = 10'd0;
        load_data = 32'h0;
        idle();
        step();
        step();
        test_reset();
        step();
        rst_n = 1'b1;
        step();
        test_load();
        test_stream();
        test_backpressure();
        test_errors();
        test_flush();
        test_load_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
